processor_debug_responder: RTL

//  Core-side end of the debug command interface. Accepts REQ/COMMAND/TARGET/DATA from the UART

---
 rtl/processor_debug_responder.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/processor_debug_responder.sv
// processor_debug_responder
//   Core-side end of the debug command link. Takes one command at a time from
//   the UART debugger. It halts, resumes or single-steps the core, and it reads
//   or writes core registers through the register-access port. Each accepted
//   command returns exactly one VALID pulse carrying ERROR/DATA.
//
//   Build option: MIST1032ISA_DEBUG_SINGLESTEP_EN
//     defined   - SINGLESTEP issues a step pulse and waits for STEP_DONE
//     undefined - SINGLESTEP answers ERROR, oCORE_STEP_REQ is tied low and
//                 the STEP_WAIT state does not exist
//
//   Handshake: the debugger raises iDEBUG_CMD_REQ with COMMAND/TARGET/DATA.
//   These are captured on the first rising edge where oDEBUG_CMD_BUSY is low.
//   BUSY stays high from the next cycle up to and including the VALID cycle.
//   A REQ seen while BUSY is high is discarded, never queued. The core-side
//   oREG_REQ is a level held with ADDR/RW/WDATA stable until iREG_ACK is
//   sampled high.
//
//   oDEBUG_STATE mirrors the FSM encoding for observation only.

module processor_debug_responder #(
   parameter int P_TO_W = 10
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   // debugger command side
   input  logic        iDEBUG_CMD_REQ,
   output logic        oDEBUG_CMD_BUSY,
   input  logic [3:0]  iDEBUG_CMD_COMMAND,
   input  logic [7:0]  iDEBUG_CMD_TARGET,
   input  logic [31:0] iDEBUG_CMD_DATA,
   output logic        oDEBUG_CMD_VALID,
   output logic        oDEBUG_CMD_ERROR,
   output logic [31:0] oDEBUG_CMD_DATA,
   // core run control
   output logic        oCORE_STOP_REQ,
   input  logic        iCORE_STOP_ACK,
   output logic        oCORE_STEP_REQ,
   input  logic        iCORE_STEP_DONE,
   output logic        oCORE_IRQ_UNMASK,
   output logic        oCORE_HALTED,
   // register access port
   output logic        oREG_REQ,
   output logic        oREG_RW,
   output logic [7:0]  oREG_ADDR,
   output logic [31:0] oREG_WDATA,
   input  logic        iREG_ACK,
   input  logic [31:0] iREG_RDATA,
   // FSM observation
   output logic [2:0]  oDEBUG_STATE
);

   localparam logic [3:0] CMD_READ_REG   = 4'h0;
   localparam logic [3:0] CMD_WRITE_REG  = 4'h1;
   localparam logic [3:0] CMD_GO         = 4'h8;
   localparam logic [3:0] CMD_INTGO      = 4'h9;
   localparam logic [3:0] CMD_SINGLESTEP = 4'hA;
   localparam logic [3:0] CMD_STOP       = 4'hF;

   // Register 64 is the CPU ID register and is read-only.
   localparam logic [7:0] REG_CPUIDR     = 8'd64;

   // All-ones timer value: the wait has lasted 2**P_TO_W-1 cycles.
   localparam logic [P_TO_W-1:0] TO_MAX  = '1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DISPATCH  = 3'd1,
      ST_STOP_WAIT = 3'd2,
`ifdef MIST1032ISA_DEBUG_SINGLESTEP_EN
      ST_STEP_WAIT = 3'd3,
`endif
      ST_REG_WAIT  = 3'd4,
      ST_RESP      = 3'd5
   } state_t;

   state_t              state;
   logic                busy_q;
   logic                valid_q;
   logic                err_q;
   logic [31:0]         rdata_q;
   logic                stop_req_q;
   logic                irq_unmask_q;
   logic                halted_q;
   logic                reg_req_q;
   logic                reg_rw_q;
   logic [3:0]          cmd_q;
   logic [7:0]          target_q;
   logic [31:0]         wdata_q;
   logic [P_TO_W-1:0]   timer_q;

`ifdef MIST1032ISA_DEBUG_SINGLESTEP_EN
   logic                step_req_q;
`else
   // Step handshake input has no consumer when single-step is compiled out.
   logic                unused_step_done;
   assign unused_step_done = iCORE_STEP_DONE;
`endif

   // Register file map: GPRs 0-31, system registers 64-78, debug registers 128-132.
   function automatic logic target_ok(input logic [7:0] t);
      return (t <= 8'd31) ||
             ((t >= 8'd64)  && (t <= 8'd78)) ||
             ((t >= 8'd128) && (t <= 8'd132));
   endfunction

   // Command FSM. All outputs are registered here. VALID, IRQ_UNMASK and
   // STEP_REQ default low each cycle, so setting them once gives a one-cycle pulse.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state        <= ST_IDLE;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
         stop_req_q   <= 1'b0;
         irq_unmask_q <= 1'b0;
         halted_q     <= 1'b0;
         reg_req_q    <= 1'b0;
         reg_rw_q     <= 1'b0;
         cmd_q        <= '0;
         target_q     <= '0;
         wdata_q      <= '0;
         timer_q      <= '0;
`ifdef MIST1032ISA_DEBUG_SINGLESTEP_EN
         step_req_q   <= 1'b0;
`endif
      end else begin
         valid_q      <= 1'b0;
         irq_unmask_q <= 1'b0;
`ifdef MIST1032ISA_DEBUG_SINGLESTEP_EN
         step_req_q   <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (iDEBUG_CMD_REQ && !busy_q) begin
                  cmd_q    <= iDEBUG_CMD_COMMAND;
                  target_q <= iDEBUG_CMD_TARGET;
                  wdata_q  <= iDEBUG_CMD_DATA;
                  busy_q   <= 1'b1;
                  state    <= ST_DISPATCH;
               end
            end

            ST_DISPATCH: begin
               // Every wait state starts counting from zero.
               timer_q <= '0;
               case (cmd_q)
                  CMD_READ_REG, CMD_WRITE_REG: begin
                     if (!halted_q || !target_ok(target_q) ||
                         ((cmd_q == CMD_WRITE_REG) && (target_q == REG_CPUIDR))) begin
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state   <= ST_RESP;
                     end else begin
                        reg_req_q <= 1'b1;
                        reg_rw_q  <= (cmd_q == CMD_WRITE_REG);
                        state     <= ST_REG_WAIT;
                     end
                  end
                  CMD_GO, CMD_INTGO: begin
                     // Resume is unconditional; it is harmless while already running.
                     stop_req_q   <= 1'b0;
                     halted_q     <= 1'b0;
                     irq_unmask_q <= (cmd_q == CMD_INTGO);
                     valid_q      <= 1'b1;
                     state        <= ST_RESP;
                  end
                  CMD_SINGLESTEP: begin
`ifdef MIST1032ISA_DEBUG_SINGLESTEP_EN
                     if (!halted_q) begin
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state   <= ST_RESP;
                     end else begin
                        step_req_q <= 1'b1;
                        state      <= ST_STEP_WAIT;
                     end
`else
                     err_q   <= 1'b1;
                     valid_q <= 1'b1;
                     state   <= ST_RESP;
`endif
                  end
                  CMD_STOP: begin
                     if (halted_q) begin
                        valid_q <= 1'b1;
                        state   <= ST_RESP;
                     end else begin
                        stop_req_q <= 1'b1;
                        state      <= ST_STOP_WAIT;
                     end
                  end
                  default: begin
                     err_q   <= 1'b1;
                     valid_q <= 1'b1;
                     state   <= ST_RESP;
                  end
               endcase
            end

            ST_STOP_WAIT: begin
               // Acknowledge is checked first so it wins over a same-cycle timeout.
               if (iCORE_STOP_ACK) begin
                  halted_q <= 1'b1;
                  valid_q  <= 1'b1;
                  state    <= ST_RESP;
               end else if (timer_q == TO_MAX) begin
                  // The core never drained: withdraw the request and leave it running.
                  stop_req_q <= 1'b0;
                  err_q      <= 1'b1;
                  valid_q    <= 1'b1;
                  state      <= ST_RESP;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

`ifdef MIST1032ISA_DEBUG_SINGLESTEP_EN
            ST_STEP_WAIT: begin
               // The core stays halted after the step retires.
               if (iCORE_STEP_DONE) begin
                  valid_q <= 1'b1;
                  state   <= ST_RESP;
               end else if (timer_q == TO_MAX) begin
                  err_q   <= 1'b1;
                  valid_q <= 1'b1;
                  state   <= ST_RESP;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
`endif

            ST_REG_WAIT: begin
               if (iREG_ACK) begin
                  reg_req_q <= 1'b0;
                  rdata_q   <= reg_rw_q ? 32'd0 : iREG_RDATA;
                  valid_q   <= 1'b1;
                  state     <= ST_RESP;
               end else if (timer_q == TO_MAX) begin
                  reg_req_q <= 1'b0;
                  err_q     <= 1'b1;
                  valid_q   <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            ST_RESP: begin
               // ERROR/DATA return to zero together with VALID.
               busy_q  <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
               state   <= ST_IDLE;
            end

            default: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign oDEBUG_CMD_BUSY  = busy_q;
   assign oDEBUG_CMD_VALID = valid_q;
   assign oDEBUG_CMD_ERROR = err_q;
   assign oDEBUG_CMD_DATA  = rdata_q;
   assign oCORE_STOP_REQ   = stop_req_q;
   assign oCORE_IRQ_UNMASK = irq_unmask_q;
   assign oCORE_HALTED     = halted_q;
   assign oREG_REQ         = reg_req_q;
   assign oREG_RW          = reg_rw_q;
   assign oREG_ADDR        = target_q;
   assign oREG_WDATA       = wdata_q;
   assign oDEBUG_STATE     = state;

`ifdef MIST1032ISA_DEBUG_SINGLESTEP_EN
   assign oCORE_STEP_REQ   = step_req_q;
`else
   assign oCORE_STEP_REQ   = 1'b0;
`endif

endmodule
